// File: rtl/sbqm_teller_ctrl_if.sv
// Teller-side signal bundle of the queue manager's front-end controller.
// slave = the controller, master = whatever drives the teller stations.
interface sbqm_teller_ctrl_if;
    logic [2:0] tOpen;
    logic [2:0] tReq;
    logic       empty;
    logic       frontPC;
    logic [1:0] Tcount;
    logic       callValid;
    logic [1:0] callTeller;
    logic [2:0] tAck;
    logic       noShow;

    modport master (
        output tOpen, tReq, empty, frontPC,
        input  Tcount, callValid, callTeller, tAck, noShow
    );

    modport slave (
        input  tOpen, tReq, empty, frontPC,
        output Tcount, callValid, callTeller, tAck, noShow
    );
endinterface

// File: rtl/sbqm_teller_ctrl.sv
// Service-side controller: round-robin grants of "next customer" requests
// from three tellers, confirmed by the front photocell, with no-show timeout.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no call outstanding; grant the next pending teller if queue non-empty
// CALL  | teller announced; waiting for the customer to break the beam
// PASS  | beam broken; waiting for it to clear to confirm the customer left
module sbqm_teller_ctrl #(
    parameter int unsigned TIMEOUT = 31
) (
    input logic clk,
    input logic rst,
    sbqm_teller_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALL = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [2:0] pending, pending_nxt;
    logic [1:0] rr, rr_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [1:0] teller, teller_nxt;
    logic [1:0] teller_idx;
    logic [2:0] teller_oh;
    logic       called_open;
    logic       pc_q;
    logic       fall_q;
    logic [2:0] eligible;
    logic [1:0] c0, c1, c2;
    logic [1:0] pick;
    logic       pick_valid;
    logic [2:0] grant_mask;
    logic [2:0] ack_nxt;
    logic       no_show_nxt;
    logic [2:0] ack_q;
    logic       no_show_q;
    logic [1:0] tcount_q;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign teller_idx  = teller - 2'd1;
    assign called_open = |(bus.tOpen & teller_oh);
    assign eligible    = pending & bus.tOpen;

    // One-hot of the teller currently being called (zero when none).
    always_comb begin
        teller_oh = 3'b000;
        case (teller)
            2'd1:    teller_oh = 3'b001;
            2'd2:    teller_oh = 3'b010;
            2'd3:    teller_oh = 3'b100;
            default: teller_oh = 3'b000;
        endcase
    end

    // Round-robin pick: first eligible teller starting at rr.
    always_comb begin
        c0         = rr;
        c1         = inc3(rr);
        c2         = inc3(c1);
        pick       = 2'd0;
        pick_valid = 1'b0;
        if (eligible[c0]) begin
            pick       = c0;
            pick_valid = 1'b1;
        end else if (eligible[c1]) begin
            pick       = c1;
            pick_valid = 1'b1;
        end else if (eligible[c2]) begin
            pick       = c2;
            pick_valid = 1'b1;
        end
    end

    // Next-state and registered-output decode; a closed called teller aborts silently.
    always_comb begin
        state_nxt    = state;
        teller_nxt   = teller;
        rr_nxt       = rr;
        wait_cnt_nxt = wait_cnt;
        ack_nxt      = 3'b000;
        no_show_nxt  = 1'b0;
        grant_mask   = 3'b000;
        case (state)
            ST_IDLE: begin
                if (pick_valid && !bus.empty) begin
                    grant_mask   = 3'b001 << pick;
                    teller_nxt   = pick + 2'd1;
                    wait_cnt_nxt = TIMEOUT_LD;
                    state_nxt    = ST_CALL;
                end
            end
            ST_CALL: begin
                if (!called_open) begin
                    teller_nxt = 2'd0;
                    state_nxt  = ST_IDLE;
                end else if (fall_q) begin
                    state_nxt = ST_PASS;
                end else if (wait_cnt == 8'd0) begin
                    no_show_nxt = 1'b1;
                    rr_nxt      = inc3(teller_idx);
                    teller_nxt  = 2'd0;
                    state_nxt   = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 8'd1;
                end
            end
            ST_PASS: begin
                if (!called_open) begin
                    teller_nxt = 2'd0;
                    state_nxt  = ST_IDLE;
                end else if (bus.frontPC) begin
                    ack_nxt    = teller_oh;
                    rr_nxt     = inc3(teller_idx);
                    teller_nxt = 2'd0;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                teller_nxt = 2'd0;
                state_nxt  = ST_IDLE;
            end
        endcase
        // Closing a teller or granting it clears its request; closing wins over a new request.
        pending_nxt = (pending | (bus.tReq & bus.tOpen)) & bus.tOpen & ~grant_mask;
    end

    // State, bookkeeping and pulse outputs. The fall flag is registered so the
    // FSM acts on a beam break one edge after the photocell register sees it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pending   <= 3'b000;
            rr        <= 2'd0;
            wait_cnt  <= 8'd0;
            teller    <= 2'd0;
            pc_q      <= 1'b1;
            fall_q    <= 1'b0;
            ack_q     <= 3'b000;
            no_show_q <= 1'b0;
            tcount_q  <= 2'd0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            rr        <= rr_nxt;
            wait_cnt  <= wait_cnt_nxt;
            teller    <= teller_nxt;
            pc_q      <= bus.frontPC;
            fall_q    <= ~bus.frontPC & pc_q;
            ack_q     <= ack_nxt;
            no_show_q <= no_show_nxt;
            tcount_q  <= {1'b0, bus.tOpen[0]} + {1'b0, bus.tOpen[1]} + {1'b0, bus.tOpen[2]};
        end
    end

    assign bus.Tcount     = tcount_q;
    assign bus.callValid  = (state != ST_IDLE);
    assign bus.callTeller = teller;
    assign bus.tAck       = ack_q;
    assign bus.noShow     = no_show_q;

endmodule

// File: tb/tb_sbqm_teller_ctrl.sv
// Self-checking bench for sbqm_teller_ctrl: vector table, directed corner
// sequences, and a randomized run against a behavioural reference model.
module tb_sbqm_teller_ctrl;

    localparam int TIMEOUT = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    sbqm_teller_ctrl_if bus ();

    sbqm_teller_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] open;
        logic [2:0] req;
        logic       empty;
        logic       fp;
        logic [1:0] tc;
        logic       cv;
        logic [1:0] ct;
        logic [2:0] ack;
        logic       ns;
    } vec_t;

    vec_t vecs[9];

    // reference model state (customer-level view)
    bit [2:0] m_pend;
    int       m_rr, m_called, m_phase, m_wait, m_tc;
    bit       m_pc, m_fall;
    int       e_ack, e_ns;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.tOpen = 3'b111; bus.tReq = 3'b000; bus.empty = 1'b0; bus.frontPC = 1'b1;
        step(); step();
        check("rst Tcount", bus.Tcount, 0);
        check("rst callValid", bus.callValid, 0);
        check("rst callTeller", bus.callTeller, 0);
        check("rst tAck", bus.tAck, 0);
        check("rst noShow", bus.noShow, 0);
        rst = 1'b0;
    endtask

    task automatic pulse_req(input logic [2:0] v);
        bus.tReq = v;
        step();
        bus.tReq = 3'b000;
    endtask

    task automatic serve(input int t, input string tag);
        int k;
        k = 0;
        while (!bus.callValid && k < 20) begin step(); k++; end
        check({tag, " grant"}, bus.callValid, 1);
        check({tag, " teller"}, bus.callTeller, t);
        bus.frontPC = 1'b0;
        step();
        bus.frontPC = 1'b1;
        k = 0;
        while (bus.tAck == 3'b000 && k < 10) begin step(); k++; end
        check({tag, " tAck"}, bus.tAck, 1 << (t - 1));
        check({tag, " callValid drop"}, bus.callValid, 0);
    endtask

    task automatic model_reset();
        m_pend = 3'b000; m_rr = 0; m_called = 0; m_phase = 0; m_wait = 0;
        m_tc = 0; m_pc = 1'b1; m_fall = 1'b0; e_ack = 0; e_ns = 0;
    endtask

    task automatic model_step(input logic [2:0] op, input logic [2:0] rq,
                              input logic em, input logic fp);
        int idx;
        int g;
        e_ack = 0; e_ns = 0; g = -1;
        if (m_called != 0) begin
            idx = m_called - 1;
            if (!op[idx]) begin
                m_called = 0;
            end else if (m_phase == 0) begin
                if (m_fall) m_phase = 1;
                else if (m_wait == TIMEOUT) begin
                    e_ns = 1; m_rr = (idx + 1) % 3; m_called = 0;
                end else m_wait++;
            end else if (fp) begin
                e_ack = 1 << idx; m_rr = (idx + 1) % 3; m_called = 0;
            end
        end else if (!em) begin
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (m_rr + k) % 3;
                if (g < 0 && m_pend[c] && op[c]) g = c;
            end
            if (g >= 0) begin m_called = g + 1; m_phase = 0; m_wait = 0; end
        end
        for (int i = 0; i < 3; i++) begin
            if (!op[i] || i == g) m_pend[i] = 1'b0;
            else if (rq[i]) m_pend[i] = 1'b1;
        end
        m_tc   = int'(op[0]) + int'(op[1]) + int'(op[2]);
        m_fall = !fp && m_pc;
        m_pc   = fp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int j, cnt, lowcnt;
        bit seen_ns, ack_seen;
        logic [2:0] r_open, r_req;
        logic r_em, r_fp;

        vecs[0] = '{3'b111, 3'b000, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 3'b000, 1'b0};
        vecs[1] = '{3'b111, 3'b001, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 3'b000, 1'b0};
        vecs[2] = '{3'b111, 3'b000, 1'b0, 1'b1, 2'd3, 1'b1, 2'd1, 3'b000, 1'b0};
        vecs[3] = '{3'b111, 3'b000, 1'b0, 1'b0, 2'd3, 1'b1, 2'd1, 3'b000, 1'b0};
        vecs[4] = '{3'b111, 3'b000, 1'b0, 1'b0, 2'd3, 1'b1, 2'd1, 3'b000, 1'b0};
        vecs[5] = '{3'b111, 3'b000, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 3'b001, 1'b0};
        vecs[6] = '{3'b111, 3'b000, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 3'b000, 1'b0};
        vecs[7] = '{3'b101, 3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 3'b000, 1'b0};
        vecs[8] = '{3'b000, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 1'b0};

        bus.tOpen = 3'b111; bus.tReq = 3'b000; bus.empty = 1'b0; bus.frontPC = 1'b1;

        // basic call / photocell pass as a vector table
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            bus.tOpen = vecs[i].open; bus.tReq = vecs[i].req;
            bus.empty = vecs[i].empty; bus.frontPC = vecs[i].fp;
            step();
            check($sformatf("vec%0d Tcount", i), bus.Tcount, vecs[i].tc);
            check($sformatf("vec%0d callValid", i), bus.callValid, vecs[i].cv);
            check($sformatf("vec%0d callTeller", i), bus.callTeller, vecs[i].ct);
            check($sformatf("vec%0d tAck", i), bus.tAck, vecs[i].ack);
            check($sformatf("vec%0d noShow", i), bus.noShow, vecs[i].ns);
        end

        // round robin from rr=0, then from rr=1
        reset_dut();
        pulse_req(3'b111);
        serve(1, "rr0 first");
        serve(2, "rr0 second");
        serve(3, "rr0 third");
        pulse_req(3'b001);
        serve(1, "rr setup");
        pulse_req(3'b111);
        serve(2, "rr1 first");
        serve(3, "rr1 second");
        serve(1, "rr1 third");

        // no-show timeout, with a request from teller 1 queued during the call
        reset_dut();
        pulse_req(3'b010);
        j = 0;
        while (!bus.callValid && j < 10) begin step(); j++; end
        check("ns teller", bus.callTeller, 2);
        bus.tReq = 3'b001;
        j = 0; seen_ns = 0; ack_seen = 0;
        while (!seen_ns && j < 40) begin
            step(); j++;
            bus.tReq = 3'b000;
            if (bus.tAck != 3'b000) ack_seen = 1;
            if (bus.noShow) seen_ns = 1;
        end
        check("ns seen", int'(seen_ns), 1);
        check("ns edge", j, TIMEOUT + 1);
        check("ns no tAck", int'(ack_seen), 0);
        check("ns callValid", bus.callValid, 0);
        step();
        check("ns pulse width", bus.noShow, 0);
        serve(1, "ns next");

        // empty gating
        reset_dut();
        bus.empty = 1'b1;
        pulse_req(3'b100);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin step(); if (bus.callValid) cnt++; end
        check("empty no call", cnt, 0);
        bus.empty = 1'b0;
        step();
        check("empty release cv", bus.callValid, 1);
        check("empty release teller", bus.callTeller, 3);

        // abort by closing the called teller
        reset_dut();
        pulse_req(3'b001);
        step();
        check("abort granted", bus.callTeller, 1);
        check("abort Tcount before", bus.Tcount, 3);
        bus.tOpen = 3'b110;
        step();
        check("abort callValid", bus.callValid, 0);
        check("abort tAck", bus.tAck, 0);
        check("abort noShow", bus.noShow, 0);
        check("abort Tcount after", bus.Tcount, 2);
        bus.tOpen = 3'b111;
        step();

        // reset while in PASS
        pulse_req(3'b001);
        step();
        bus.frontPC = 1'b0;
        step(); step();
        check("pass callValid", bus.callValid, 1);
        rst = 1'b1;
        step();
        check("passrst Tcount", bus.Tcount, 0);
        check("passrst callValid", bus.callValid, 0);
        check("passrst callTeller", bus.callTeller, 0);
        check("passrst tAck", bus.tAck, 0);
        check("passrst noShow", bus.noShow, 0);
        rst = 1'b0;
        bus.frontPC = 1'b1;
        step();
        check("passrst no late ack", bus.tAck, 0);

        // randomized run against the reference model
        reset_dut();
        model_reset();
        r_open = 3'b111; lowcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                j = $urandom_range(0, 2);
                r_open[j] = ~r_open[j];
            end
            for (int i = 0; i < 3; i++) r_req[i] = ($urandom_range(0, 7) == 0);
            r_em = ($urandom_range(0, 9) == 0);
            if (lowcnt > 0) begin
                r_fp = 1'b0; lowcnt--;
            end else begin
                r_fp = 1'b1;
                if ($urandom_range(0, 15) == 0) lowcnt = $urandom_range(1, 3);
            end
            bus.tOpen = r_open; bus.tReq = r_req; bus.empty = r_em; bus.frontPC = r_fp;
            step();
            model_step(r_open, r_req, r_em, r_fp);
            check("rnd Tcount", bus.Tcount, m_tc);
            check("rnd callValid", bus.callValid, (m_called != 0) ? 1 : 0);
            check("rnd callTeller", bus.callTeller, m_called);
            check("rnd tAck", bus.tAck, e_ack);
            check("rnd noShow", bus.noShow, e_ns);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
